// File: rtl/hash_round_controller_pkg.sv
// Shared types and default dimensions for the hash round controller.
package hash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        ROUND_EXEC  = 3'd2,
        FINAL_ROUND = 3'd3,
        DONE        = 3'd4
    } ctrl_state_t;

    localparam int HASH_N_ROUNDS = 36;
    localparam int HASH_STEPS    = 8;

endpackage

// File: rtl/hash_round_controller_if.sv
// Host byte stream, datapath control and digest handshake of the hash round controller.
interface hash_round_controller_if
    import hash_ctrl_pkg::*;
#(
    parameter int N_ROUNDS = HASH_N_ROUNDS,
    parameter int STEPS    = HASH_STEPS
) ();

    localparam int SW = $clog2(STEPS);
    localparam int RW = $clog2(N_ROUNDS);

    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          init_state;
    logic          byte_load;
    logic          round_exec_active;
    logic          final_round_active;
    logic [SW-1:0] i_count;
    logic [RW-1:0] round_count;
    logic          round_done;
    logic          digest_valid;
    logic          digest_ack;
    logic          busy;
    ctrl_state_t   state;

    modport master (
        output start, abort, in_valid, in_last, digest_ack,
        input  in_ready, init_state, byte_load, round_exec_active,
               final_round_active, i_count, round_count, round_done,
               digest_valid, busy, state
    );

    modport slave (
        input  start, abort, in_valid, in_last, digest_ack,
        output in_ready, init_state, byte_load, round_exec_active,
               final_round_active, i_count, round_count, round_done,
               digest_valid, busy, state
    );

endinterface

// File: rtl/hash_round_controller_step_counter.sv
// Step index within a round and round index within a byte, with wrap flags.
module hash_step_counter
    import hash_ctrl_pkg::*;
#(
    parameter int N_ROUNDS = HASH_N_ROUNDS,
    parameter int STEPS    = HASH_STEPS,
    localparam int SW = $clog2(STEPS),
    localparam int RW = $clog2(N_ROUNDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_step_en,
    input  logic          i_round_en,
    output logic [SW-1:0] o_i_count,
    output logic [RW-1:0] o_round_count,
    output logic          o_step_wrap,
    output logic          o_round_wrap
);

    logic [SW-1:0] r_i_count;
    logic [RW-1:0] r_round_count;
    logic          w_step_wrap;
    logic          w_round_wrap;

    assign w_step_wrap  = (r_i_count == SW'(STEPS - 1));
    assign w_round_wrap = (r_round_count == RW'(N_ROUNDS - 1));

    // round index only advances when the step index wraps and rounds are enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_count     <= '0;
            r_round_count <= '0;
        end else if (i_clr) begin
            r_i_count     <= '0;
            r_round_count <= '0;
        end else if (i_step_en) begin
            if (w_step_wrap) begin
                r_i_count <= '0;
                if (i_round_en)
                    r_round_count <= w_round_wrap ? '0 : r_round_count + RW'(1);
            end else begin
                r_i_count <= r_i_count + SW'(1);
            end
        end
    end

    assign o_i_count     = r_i_count;
    assign o_round_count = r_round_count;
    assign o_step_wrap   = w_step_wrap;
    assign o_round_wrap  = w_round_wrap;

endmodule

// File: rtl/hash_round_controller.sv
// Sequences per-byte rounds and the final round of the hash core, then holds the digest flag until acked.
module hash_round_controller
    import hash_ctrl_pkg::*;
#(
    parameter int N_ROUNDS = HASH_N_ROUNDS,
    parameter int STEPS    = HASH_STEPS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hash_round_controller_if.slave  bus
);

    localparam int SW = $clog2(STEPS);
    localparam int RW = $clog2(N_ROUNDS);

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          w_clr;
    logic          w_step_en;
    logic          w_round_en;
    logic          w_init_state;
    logic          w_byte_load;
    logic [SW-1:0] w_i_count;
    logic [RW-1:0] w_round_count;
    logic          w_step_wrap;
    logic          w_round_wrap;

    hash_step_counter #(
        .N_ROUNDS (N_ROUNDS),
        .STEPS    (STEPS)
    ) u_step_counter (
        .clk           (clk),
        .rst_n         (reset_n),
        .i_clr         (w_clr),
        .i_step_en     (w_step_en),
        .i_round_en    (w_round_en),
        .o_i_count     (w_i_count),
        .o_round_count (w_round_count),
        .o_step_wrap   (w_step_wrap),
        .o_round_wrap  (w_round_wrap)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_clr        = 1'b0;
        w_step_en    = 1'b0;
        w_round_en   = 1'b0;
        w_init_state = 1'b0;
        w_byte_load  = 1'b0;
        if (r_state != IDLE && bus.abort) begin
            // abort wins over everything and suppresses this cycle's pulses
            w_state_nxt = IDLE;
            w_last_nxt  = 1'b0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_init_state = 1'b1;
                        w_state_nxt  = LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        w_byte_load = 1'b1;
                        w_last_nxt  = bus.in_last;
                        w_clr       = 1'b1;
                        w_state_nxt = ROUND_EXEC;
                    end
                end
                ROUND_EXEC: begin
                    w_step_en  = 1'b1;
                    w_round_en = 1'b1;
                    if (w_step_wrap && w_round_wrap) begin
                        w_clr       = 1'b1;
                        w_state_nxt = r_last ? FINAL_ROUND : LOAD;
                    end
                end
                FINAL_ROUND: begin
                    w_step_en = 1'b1;
                    if (w_step_wrap) begin
                        w_clr       = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (bus.digest_ack) begin
                        w_last_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = 1'b0;
                    w_clr       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.in_ready           = (r_state == LOAD);
    assign bus.init_state         = w_init_state;
    assign bus.byte_load          = w_byte_load;
    assign bus.round_exec_active  = (r_state == ROUND_EXEC);
    assign bus.final_round_active = (r_state == FINAL_ROUND);
    assign bus.i_count            = w_i_count;
    assign bus.round_count        = w_round_count;
    assign bus.round_done         = ((r_state == ROUND_EXEC) || (r_state == FINAL_ROUND)) && w_step_wrap;
    assign bus.digest_valid       = (r_state == DONE);
    assign bus.busy               = (r_state != IDLE);
    assign bus.state              = r_state;

endmodule

// File: tb/tb_hash_round_controller.sv
// Directed bench for hash_round_controller with hand-computed expectations.
module tb_hash_round_controller;
    import hash_ctrl_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hash_round_controller_if b ();

    hash_round_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start, one cycle in LOAD with a handshake, ends on the first ROUND_EXEC cycle
    task automatic begin_msg(input logic last);
        b.start = 1'b1;
        step();
        b.start    = 1'b0;
        b.in_valid = 1'b1;
        b.in_last  = last;
        step();
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask

    task automatic wait_digest(output int n);
        n = 0;
        while (!b.digest_valid && n < 400) begin
            n++;
            step();
        end
    endtask

    task automatic ack_digest();
        b.digest_ack = 1'b1;
        step();
        b.digest_ack = 1'b0;
    endtask

    initial begin
        int n;
        int rd;
        int bad;
        int loads;
        int rc35;
        int cyc;
        int ld_cyc[3];

        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        b.start      = 1'b0;
        b.abort      = 1'b0;
        b.in_valid   = 1'b0;
        b.in_last    = 1'b0;
        b.digest_ack = 1'b0;

        #12;
        chk("rst_state", b.state, IDLE);
        chk("rst_busy", b.busy, 0);
        chk("rst_icount", b.i_count, 0);
        chk("rst_rcount", b.round_count, 0);
        chk("rst_in_ready", b.in_ready, 0);
        chk("rst_digest", b.digest_valid, 0);
        reset_n = 1'b1;
        step();

        // abort in IDLE does nothing
        b.abort = 1'b1;
        step();
        b.abort = 1'b0;
        chk("idle_abort_state", b.state, IDLE);

        // single byte message
        b.start = 1'b1;
        #1;
        chk("t1_init_pulse", b.init_state, 1);
        chk("t1_state_idle", b.state, IDLE);
        step();
        b.start = 1'b0;
        chk("t1_state_load", b.state, LOAD);
        chk("t1_in_ready", b.in_ready, 1);
        chk("t1_init_low", b.init_state, 0);
        b.in_valid = 1'b1;
        b.in_last  = 1'b1;
        #1;
        chk("t1_byte_load", b.byte_load, 1);
        step();
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        chk("t1_re_icount0", b.i_count, 0);
        chk("t1_re_rcount0", b.round_count, 0);
        chk("t1_in_ready_re", b.in_ready, 0);
        n = 0; rd = 0;
        while (b.round_exec_active && n < 400) begin
            n++;
            if (b.round_done) rd++;
            step();
        end
        chk("t1_round_cycles", n, 288);
        chk("t1_round_done_re", rd, 36);
        n = 0; bad = 0;
        while (b.final_round_active && n < 20) begin
            n++;
            if (b.round_done) rd++;
            if (b.round_count != 0) bad++;
            step();
        end
        chk("t1_final_cycles", n, 8);
        chk("t1_round_done_all", rd, 37);
        chk("t1_final_rcount0", bad, 0);
        chk("t1_digest", b.digest_valid, 1);
        chk("t1_state_done", b.state, DONE);
        step(); step(); step();
        chk("t1_digest_held", b.digest_valid, 1);
        ack_digest();
        chk("t1_idle", b.state, IDLE);
        chk("t1_busy", b.busy, 0);
        chk("t1_digest_clr", b.digest_valid, 0);

        // in_valid withheld in LOAD, then three back-to-back bytes
        b.start = 1'b1;
        step();
        b.start = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (b.state != LOAD || !b.in_ready || b.i_count != 0 || b.round_count != 0) bad++;
            step();
        end
        chk("t2_wait_load", bad, 0);
        chk("t2_still_load", b.state, LOAD);
        b.in_valid = 1'b1;
        b.in_last  = 1'b0;
        loads = 0; rc35 = 0; cyc = 0;
        for (int k = 0; k < 1200 && !b.final_round_active; k++) begin
            if (b.round_exec_active && loads == 2) b.in_last = 1'b1;
            #1;
            if (b.byte_load) begin
                if (loads < 3) ld_cyc[loads] = cyc;
                loads++;
            end
            if (b.round_exec_active && b.round_count == 35 && b.i_count == 7) rc35++;
            cyc++;
            step();
        end
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        chk("t2_loads", loads, 3);
        chk("t2_gap01", ld_cyc[1] - ld_cyc[0], 289);
        chk("t2_gap12", ld_cyc[2] - ld_cyc[1], 289);
        chk("t2_rc35", rc35, 3);
        chk("t2_final", b.final_round_active, 1);
        chk("t2_in_ready_final", b.in_ready, 0);
        wait_digest(n);
        chk("t2_final_len", n, 8);
        ack_digest();
        chk("t2_idle", b.state, IDLE);

        // abort mid ROUND_EXEC
        begin_msg(1'b1);
        n = 0;
        while (!(b.round_count == 17 && b.i_count == 3) && n < 400) begin
            n++;
            step();
        end
        chk("t3_abort_point", n, 17 * 8 + 3);
        b.abort = 1'b1;
        #1;
        chk("t3_no_pulse", b.byte_load | b.init_state, 0);
        step();
        b.abort = 1'b0;
        chk("t3_state", b.state, IDLE);
        chk("t3_icount", b.i_count, 0);
        chk("t3_rcount", b.round_count, 0);
        chk("t3_digest", b.digest_valid, 0);
        chk("t3_busy", b.busy, 0);
        begin_msg(1'b1);
        wait_digest(n);
        chk("t3_restart_len", n, 296);

        // delayed ack with a start pulse inside DONE
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            b.start = (k == 5);
            #1;
            if (!b.digest_valid || b.state != DONE || b.init_state) bad++;
            step();
        end
        b.start = 1'b0;
        chk("t4_hold", bad, 0);
        chk("t4_still_done", b.state, DONE);
        ack_digest();
        chk("t4_idle", b.state, IDLE);
        chk("t4_digest_clr", b.digest_valid, 0);

        // asynchronous reset during FINAL_ROUND
        begin_msg(1'b1);
        n = 0;
        while (!b.final_round_active && n < 400) begin
            n++;
            step();
        end
        chk("t5_reach_final", b.final_round_active, 1);
        step(); step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_state", b.state, IDLE);
        chk("t5_final_low", b.final_round_active, 0);
        chk("t5_icount", b.i_count, 0);
        chk("t5_busy", b.busy, 0);
        chk("t5_round_done", b.round_done, 0);
        step(); step();
        #2;
        reset_n = 1'b1;
        step();
        chk("t5_after_state", b.state, IDLE);
        chk("t5_no_digest", b.digest_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
